// File: rtl/fifo_flagged_if.sv
// fifo_flagged_if: handshake/status bundle of fifo_flagged.
// master drives push/pop/flush/clear_err/data_in; slave is the FIFO.
interface fifo_flagged_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4
);
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  clear_err;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;
  logic [ADDR_WIDTH:0]   fifo_count;

  modport master (
    output push, pop, flush, clear_err, data_in,
    input  data_out, empty, full, almost_empty,
    input  almost_full, overflow, underflow, fifo_count
  );

  modport slave (
    input  push, pop, flush, clear_err, data_in,
    output data_out, empty, full, almost_empty,
    output almost_full, overflow, underflow, fifo_count
  );
endinterface

// File: rtl/fifo_flagged.sv
// fifo_flagged: single-clock FIFO, any depth, std/FWFT read, flags.
// Ports: clk, reset (async active-low), io (fifo_flagged_if.slave).
module fifo_flagged #(
  parameter int DATA_WIDTH          = 64,
  parameter int ADDR_WIDTH          = 4,
  parameter int RAM_DEPTH           = 1 << ADDR_WIDTH,
  parameter int FWFT                = 0,
  parameter int ALMOST_FULL_THRESH  = RAM_DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESH = 2,
  parameter     TYPE                = "MLAB"
) (
  input logic           clk,
  input logic           reset,
  fifo_flagged_if.slave io
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RAM_DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(ALMOST_FULL_THRESH);
  localparam logic [CW-1:0] AE_C = CW'(ALMOST_EMPTY_THRESH);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  if (ALMOST_EMPTY_THRESH >= ALMOST_FULL_THRESH) begin : g_bad_ae
    $fatal(1, "fifo_flagged: ALMOST_EMPTY_THRESH >= ALMOST_FULL_THRESH");
  end
  if (ALMOST_FULL_THRESH > RAM_DEPTH) begin : g_bad_af
    $fatal(1, "fifo_flagged: ALMOST_FULL_THRESH > RAM_DEPTH");
  end
  if (RAM_DEPTH < 2 || RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_d
    $fatal(1, "fifo_flagged: RAM_DEPTH out of range");
  end
  if (TYPE == "") begin : g_bad_type
    $fatal(1, "fifo_flagged: TYPE must name a RAM style");
  end

  (* ramstyle = TYPE *)
  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] wr_nxt, rd_nxt;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  empty, full, push_acc, pop_acc;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DEPTH_C);

  assign push_acc = io.push & ~full & ~io.flush;
  assign pop_acc  = io.pop & ~empty & ~io.flush;

  // Explicit wrap so non-power-of-two depths work.
  assign wr_nxt = (wr_q == LAST) ? '0 : wr_q + 1'b1;
  assign rd_nxt = (rd_q == LAST) ? '0 : rd_q + 1'b1;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (io.flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_acc) wr_d = wr_nxt;
      if (pop_acc)  rd_d = rd_nxt;
      if (push_acc && !pop_acc)      cnt_d = cnt_q + 1'b1;
      else if (pop_acc && !push_acc) cnt_d = cnt_q - 1'b1;
    end
  end

  // FWFT: dout_q always mirrors the head word. A new word enters
  // from data_in when the FIFO is (or is about to be) empty,
  // otherwise from the slot behind the head on a pop.
  always_comb begin
    dout_d = dout_q;
    if (FWFT != 0) begin
      if (push_acc && (empty || (pop_acc && cnt_q == ONE_C)))
        dout_d = io.data_in;
      else if (pop_acc && cnt_q > ONE_C)
        dout_d = mem_q[rd_nxt];
    end else if (pop_acc) begin
      dout_d = mem_q[rd_q];
    end
  end

  // New error wins over clear in the same cycle.
  assign ovf_d = (ovf_q & ~io.clear_err)
               | (io.push & full & ~io.flush);
  assign unf_d = (unf_q & ~io.clear_err)
               | (io.pop & empty & ~io.flush);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_q] <= io.data_in;
  end

  assign io.data_out     = dout_q;
  assign io.fifo_count   = cnt_q;
  assign io.empty        = empty;
  assign io.full         = full;
  assign io.almost_empty = (cnt_q <= AE_C);
  assign io.almost_full  = (cnt_q >= AF_C);
  assign io.overflow     = ovf_q;
  assign io.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_flagged.sv
// tb_fifo_flagged: std and FWFT instances (depth 6) driven in
// lockstep; table vectors, corner sequences, random vs queue model.
module tb_fifo_flagged;

  localparam int DEPTH = 6;

  logic clk;
  logic rst_n;

  fifo_flagged_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) if_s ();
  fifo_flagged_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) if_f ();

  assign if_f.push      = if_s.push;
  assign if_f.pop       = if_s.pop;
  assign if_f.flush     = if_s.flush;
  assign if_f.clear_err = if_s.clear_err;
  assign if_f.data_in   = if_s.data_in;

  fifo_flagged #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .RAM_DEPTH(DEPTH), .FWFT(0)
  ) u_std (.clk(clk), .reset(rst_n), .io(if_s));

  fifo_flagged #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .RAM_DEPTH(DEPTH), .FWFT(1)
  ) u_fw (.clk(clk), .reset(rst_n), .io(if_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue contents plus read registers and flags.
  logic [7:0] mq[$];
  logic [7:0] m_ds, m_df;
  logic       m_ovf, m_unf;

  typedef struct {
    bit         push, pop, flush, clr;
    logic [7:0] din;
    int         cnt;
    logic [7:0] dout;
    bit         ovf, unf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ds  = '0;
    m_df  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(bit ps, bit pp, bit fl, bit cl,
                            logic [7:0] d);
    bit mfull, mempty;
    mfull  = (mq.size() == DEPTH);
    mempty = (mq.size() == 0);
    if (cl) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (ps && mfull && !fl) m_ovf = 1'b1;
    if (pp && mempty && !fl) m_unf = 1'b1;
    if (fl) begin
      mq.delete();
    end else begin
      if (pp && !mempty) m_ds = mq.pop_front();
      if (ps && !mfull) mq.push_back(d);
    end
    if (mq.size() > 0) m_df = mq[0];
  endtask

  task automatic check_all();
    int c;
    c = mq.size();
    chk("s_count", 64'(if_s.fifo_count), 64'(c));
    chk("s_empty", 64'(if_s.empty), 64'(c == 0));
    chk("s_full", 64'(if_s.full), 64'(c == DEPTH));
    chk("s_aempty", 64'(if_s.almost_empty), 64'(c <= 2));
    chk("s_afull", 64'(if_s.almost_full), 64'(c >= DEPTH - 2));
    chk("s_ovf", 64'(if_s.overflow), 64'(m_ovf));
    chk("s_unf", 64'(if_s.underflow), 64'(m_unf));
    chk("s_dout", 64'(if_s.data_out), 64'(m_ds));
    chk("f_count", 64'(if_f.fifo_count), 64'(c));
    chk("f_empty", 64'(if_f.empty), 64'(c == 0));
    chk("f_full", 64'(if_f.full), 64'(c == DEPTH));
    chk("f_ovf", 64'(if_f.overflow), 64'(m_ovf));
    chk("f_unf", 64'(if_f.underflow), 64'(m_unf));
    chk("f_dout", 64'(if_f.data_out), 64'(m_df));
  endtask

  task automatic drive(bit ps, bit pp, bit fl, bit cl,
                       logic [7:0] d);
    if_s.push      = ps;
    if_s.pop       = pp;
    if_s.flush     = fl;
    if_s.clear_err = cl;
    if_s.data_in   = d;
  endtask

  task automatic cyc(bit ps, bit pp, bit fl, bit cl, logic [7:0] d);
    drive(ps, pp, fl, cl, d);
    @(posedge clk);
    #1;
    model_step(ps, pp, fl, cl, d);
    check_all();
  endtask

  function automatic void add(bit ps, bit pp, bit fl, bit cl,
                              logic [7:0] d, int cnt,
                              logic [7:0] dout, bit ovf, bit unf);
    vec_t v;
    v.push = ps; v.pop = pp; v.flush = fl; v.clr = cl;
    v.din = d; v.cnt = cnt; v.dout = dout;
    v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  initial begin
    // Expected standard-mode results, written from the rules.
    for (int i = 0; i < 6; i++)
      add(1, 0, 0, 0, 8'h10 + 8'(i), i + 1, 8'h00, 0, 0);
    for (int i = 0; i < 6; i++)
      add(0, 1, 0, 0, 8'h00, 5 - i, 8'h10 + 8'(i), 0, 0);
    for (int i = 0; i < 4; i++)
      add(1, 0, 0, 0, 8'h20 + 8'(i), i + 1, 8'h15, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 0, 8'h00, 3 - i, 8'h20 + 8'(i), 0, 0);
    for (int i = 0; i < 6; i++)
      add(1, 0, 0, 0, 8'h30 + 8'(i), i + 1, 8'h23, 0, 0);
    add(1, 1, 0, 0, 8'hAA, 5, 8'h30, 1, 0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 0, 0, 8'h00, 4 - i, 8'h31 + 8'(i), 1, 0);
    add(1, 1, 0, 0, 8'h55, 1, 8'h35, 1, 1);
    add(0, 0, 0, 1, 8'h00, 1, 8'h35, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 8'h55, 0, 0);
    for (int i = 0; i < 4; i++)
      add(1, 0, 0, 0, 8'h40 + 8'(i), i + 1, 8'h55, 0, 0);
    add(1, 0, 1, 0, 8'h99, 0, 8'h55, 0, 0);
    add(1, 0, 0, 0, 8'h50, 1, 8'h55, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 8'h50, 0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 8'h00);
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      cyc(vecs[k].push, vecs[k].pop, vecs[k].flush, vecs[k].clr,
          vecs[k].din);
      chk("t_count", 64'(if_s.fifo_count), 64'(vecs[k].cnt));
      chk("t_dout", 64'(if_s.data_out), 64'(vecs[k].dout));
      chk("t_ovf", 64'(if_s.overflow), 64'(vecs[k].ovf));
      chk("t_unf", 64'(if_s.underflow), 64'(vecs[k].unf));
    end

    // Async reset mid-cycle at count 3 with overflow set.
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 8'h60 + 8'(i));
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 8'h00);
    chk("ar_pre_cnt", 64'(if_s.fifo_count), 64'd3);
    chk("ar_pre_ovf", 64'(if_s.overflow), 64'd1);
    drive(0, 0, 0, 0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cnt", 64'(if_s.fifo_count), 64'd0);
    chk("ar_ovf", 64'(if_s.overflow), 64'd0);
    chk("ar_dout", 64'(if_s.data_out), 64'd0);
    chk("ar_empty", 64'(if_s.empty), 64'd1);
    chk("ar_afull", 64'(if_s.almost_full), 64'd0);
    chk("ar_f_dout", 64'(if_f.data_out), 64'd0);
    model_reset();
    check_all();
    #3;
    rst_n = 1'b1;

    // FWFT corner sequence.
    cyc(1, 0, 0, 0, 8'h31);
    chk("fw_empty1", 64'(if_f.empty), 64'd0);
    chk("fw_dout1", 64'(if_f.data_out), 64'h31);
    cyc(1, 0, 0, 0, 8'h32);
    chk("fw_dout2", 64'(if_f.data_out), 64'h31);
    cyc(0, 1, 0, 0, 8'h00);
    chk("fw_dout3", 64'(if_f.data_out), 64'h32);
    cyc(0, 1, 0, 0, 8'h00);
    chk("fw_empty4", 64'(if_f.empty), 64'd1);
    chk("fw_dout4", 64'(if_f.data_out), 64'h32);
    cyc(1, 0, 0, 0, 8'h77);
    cyc(1, 1, 0, 0, 8'h78);
    chk("fw_dout5", 64'(if_f.data_out), 64'h78);

    // Random traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 9) < 6,
          $urandom_range(0, 9) < 5,
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 19) == 0,
          8'($urandom_range(0, 255)));
    end

    drive(0, 0, 0, 0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
